// File: rtl/ddr_burst_bridge.sv
// ---------------------------------------------------------------------------
// ddr_burst_bridge
//
// Responder side of the DDR burst request interface. Accepts one read or
// write burst at a time and turns it into MIG UltraScale native app
// commands (one command plus, for writes, one write-data beat per 512-bit
// beat). Read data comes back one cycle after the MIG delivers it, and each
// burst ends with a one-cycle finish pulse.
//
// Ports
//   ddr_clk, ddr_rst            MIG ui_clk and synchronous active-high reset
//   init_calib_complete         no burst is accepted until calibration is done
//   wr_burst_*                  write burst request / data handshake / finish
//   rd_burst_*                  read burst request / data return / finish
//   app_addr/cmd/en/rdy         MIG command channel
//   app_wdf_*                   MIG write-data channel (mask tied low)
//   app_rd_data, _valid         MIG read-data return
// ---------------------------------------------------------------------------
module ddr_burst_bridge #(
   parameter int DDR_ADDR_WD = 32,
   parameter int DDR_DATA_WD = 512,
   parameter int APP_ADDR_WD = 28,
   parameter int ADDR_STEP   = 8
) (
   input  logic                     ddr_clk,
   input  logic                     ddr_rst,
   input  logic                     init_calib_complete,
   input  logic                     wr_burst_req,
   input  logic [9:0]               wr_burst_len,
   input  logic [DDR_ADDR_WD-1:0]   wr_burst_addr,
   output logic                     wr_burst_data_req,
   input  logic [DDR_DATA_WD-1:0]   wr_burst_data,
   output logic                     wr_burst_finish,
   input  logic                     rd_burst_req,
   input  logic [9:0]               rd_burst_len,
   input  logic [DDR_ADDR_WD-1:0]   rd_burst_addr,
   output logic                     rd_burst_data_valid,
   output logic [DDR_DATA_WD-1:0]   rd_burst_data,
   output logic                     rd_burst_finish,
   output logic [APP_ADDR_WD-1:0]   app_addr,
   output logic [2:0]               app_cmd,
   output logic                     app_en,
   input  logic                     app_rdy,
   output logic [DDR_DATA_WD-1:0]   app_wdf_data,
   output logic                     app_wdf_wren,
   output logic                     app_wdf_end,
   output logic [DDR_DATA_WD/8-1:0] app_wdf_mask,
   input  logic                     app_wdf_rdy,
   input  logic [DDR_DATA_WD-1:0]   app_rd_data,
   input  logic                     app_rd_data_valid
);

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;

   state_t                  state_reg, state_next;
   logic                    last_grant_reg;   // 1: last accepted burst was a read
   logic [9:0]              blen_reg;
   logic [9:0]              cmd_cnt_reg, cmd_cnt_next;
   logic [9:0]              dat_cnt_reg, dat_cnt_next;
   logic [9:0]              beat_cnt_reg;
   logic [APP_ADDR_WD-1:0]  base_reg;
   logic                    wr_finish_reg, rd_finish_reg;
   logic                    rd_valid_reg;
   logic [DDR_DATA_WD-1:0]  rd_data_reg;

   logic                    accept, grant_rd, grant_zero;
   logic                    wr_done, rd_done, rd_capture;
   logic [APP_ADDR_WD-1:0]  cmd_addr;

   // Address bits above the MIG address width are intentionally discarded.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wr_burst_addr[DDR_ADDR_WD-1:APP_ADDR_WD],
                               rd_burst_addr[DDR_ADDR_WD-1:APP_ADDR_WD]};

   // Wraps silently modulo 2^APP_ADDR_WD.
   assign cmd_addr = base_reg + APP_ADDR_WD'(cmd_cnt_reg) * APP_ADDR_WD'(ADDR_STEP);

   always_ff @(posedge ddr_clk) begin
      if (ddr_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      accept            = 1'b0;
      grant_rd          = 1'b0;
      grant_zero        = 1'b0;
      wr_done           = 1'b0;
      rd_done           = 1'b0;
      rd_capture        = 1'b0;
      app_en            = 1'b0;
      app_cmd           = 3'b000;
      app_addr          = '0;
      wr_burst_data_req = 1'b0;
      cmd_cnt_next      = cmd_cnt_reg;
      dat_cnt_next      = dat_cnt_reg;
      case (state_reg)
         IDLE: begin
            // A finish pulse blocks accept so a request still held during
            // the finish cycle is not taken a second time.
            if (init_calib_complete && !wr_finish_reg && !rd_finish_reg &&
                (wr_burst_req || rd_burst_req)) begin
               accept   = 1'b1;
               // On a tie, alternate away from the last granted direction.
               grant_rd = rd_burst_req && (!wr_burst_req || !last_grant_reg);
               grant_zero = grant_rd ? (rd_burst_len == 10'd0) : (wr_burst_len == 10'd0);
               // Zero-length bursts finish straight from IDLE.
               if (!grant_zero) begin
                  state_next = grant_rd ? RD : WR;
               end
            end
         end
         WR: begin
            app_en            = (cmd_cnt_reg < blen_reg);
            app_addr          = cmd_addr;
            wr_burst_data_req = (dat_cnt_reg < blen_reg) && app_wdf_rdy;
            if (app_en && app_rdy) begin
               cmd_cnt_next = cmd_cnt_reg + 10'd1;
            end
            if (wr_burst_data_req) begin
               dat_cnt_next = dat_cnt_reg + 10'd1;
            end
            // Look at the post-edge counts so finish lands right after the
            // last command/data beat.
            if (cmd_cnt_next == blen_reg && dat_cnt_next == blen_reg) begin
               wr_done    = 1'b1;
               state_next = IDLE;
            end
         end
         RD: begin
            app_en   = (cmd_cnt_reg < blen_reg);
            app_cmd  = 3'b001;
            app_addr = cmd_addr;
            if (app_en && app_rdy) begin
               cmd_cnt_next = cmd_cnt_reg + 10'd1;
            end
            // Beats already delivered plus the one in the output register
            // bound what may still be taken; anything beyond blen is dropped.
            rd_capture = app_rd_data_valid &&
                         (({1'b0, beat_cnt_reg} + 11'(rd_valid_reg)) < {1'b0, blen_reg});
            if (rd_valid_reg && (beat_cnt_reg + 10'd1 == blen_reg)) begin
               rd_done    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge ddr_clk) begin
      if (ddr_rst) begin
         last_grant_reg <= 1'b1;
         blen_reg       <= '0;
         base_reg       <= '0;
         cmd_cnt_reg    <= '0;
         dat_cnt_reg    <= '0;
         beat_cnt_reg   <= '0;
         wr_finish_reg  <= 1'b0;
         rd_finish_reg  <= 1'b0;
         rd_valid_reg   <= 1'b0;
         rd_data_reg    <= '0;
      end else begin
         wr_finish_reg <= wr_done || (accept && !grant_rd && grant_zero);
         rd_finish_reg <= rd_done || (accept && grant_rd && grant_zero);
         rd_valid_reg  <= rd_capture;
         if (rd_capture) begin
            rd_data_reg <= app_rd_data;
         end
         if (accept) begin
            last_grant_reg <= grant_rd;
            blen_reg       <= grant_rd ? rd_burst_len : wr_burst_len;
            base_reg       <= grant_rd ? rd_burst_addr[APP_ADDR_WD-1:0]
                                       : wr_burst_addr[APP_ADDR_WD-1:0];
            cmd_cnt_reg    <= '0;
            dat_cnt_reg    <= '0;
            beat_cnt_reg   <= '0;
         end else begin
            cmd_cnt_reg <= cmd_cnt_next;
            dat_cnt_reg <= dat_cnt_next;
            if (state_reg == RD && rd_valid_reg) begin
               beat_cnt_reg <= beat_cnt_reg + 10'd1;
            end
         end
      end
   end

   assign wr_burst_finish     = wr_finish_reg;
   assign rd_burst_finish     = rd_finish_reg;
   assign rd_burst_data_valid = rd_valid_reg;
   assign rd_burst_data       = rd_data_reg;
   assign app_wdf_wren        = wr_burst_data_req;
   assign app_wdf_end         = wr_burst_data_req;
   assign app_wdf_data        = wr_burst_data_req ? wr_burst_data : '0;
   assign app_wdf_mask        = '0;

endmodule

// File: tb/tb_ddr_burst_bridge.sv
// ---------------------------------------------------------------------------
// tb_ddr_burst_bridge
//
// Directed sequence with random data and random ready patterns. A simple
// requester and a fixed-latency MIG read model are driven once per cycle;
// every observed command, data beat and finish is logged with its cycle
// number and compared against values computed from the burst parameters.
// ---------------------------------------------------------------------------
module tb_ddr_burst_bridge;

   localparam int DW = 512;
   localparam int AW = 28;
   localparam int RD_LAT = 5;

   logic            ddr_clk = 1'b0;
   logic            ddr_rst;
   logic            init_calib_complete;
   logic            wr_burst_req;
   logic [9:0]      wr_burst_len;
   logic [31:0]     wr_burst_addr;
   logic            wr_burst_data_req;
   logic [DW-1:0]   wr_burst_data;
   logic            wr_burst_finish;
   logic            rd_burst_req;
   logic [9:0]      rd_burst_len;
   logic [31:0]     rd_burst_addr;
   logic            rd_burst_data_valid;
   logic [DW-1:0]   rd_burst_data;
   logic            rd_burst_finish;
   logic [AW-1:0]   app_addr;
   logic [2:0]      app_cmd;
   logic            app_en;
   logic            app_rdy;
   logic [DW-1:0]   app_wdf_data;
   logic            app_wdf_wren;
   logic            app_wdf_end;
   logic [DW/8-1:0] app_wdf_mask;
   logic            app_wdf_rdy;
   logic [DW-1:0]   app_rd_data;
   logic            app_rd_data_valid;

   always #5 ddr_clk = ~ddr_clk;

   ddr_burst_bridge dut (
      .ddr_clk             (ddr_clk),
      .ddr_rst             (ddr_rst),
      .init_calib_complete (init_calib_complete),
      .wr_burst_req        (wr_burst_req),
      .wr_burst_len        (wr_burst_len),
      .wr_burst_addr       (wr_burst_addr),
      .wr_burst_data_req   (wr_burst_data_req),
      .wr_burst_data       (wr_burst_data),
      .wr_burst_finish     (wr_burst_finish),
      .rd_burst_req        (rd_burst_req),
      .rd_burst_len        (rd_burst_len),
      .rd_burst_addr       (rd_burst_addr),
      .rd_burst_data_valid (rd_burst_data_valid),
      .rd_burst_data       (rd_burst_data),
      .rd_burst_finish     (rd_burst_finish),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [30:0]   cmd_q[$];
   int            cmd_cyc_q[$];
   logic [DW-1:0] wdf_q[$];
   int            wdf_cyc_q[$];
   logic [DW-1:0] rdq[$];
   int            rd_cyc_q[$];
   logic [DW-1:0] mig_q[$];
   int            mig_cyc_q[$];
   int            due_q[$];
   int            fin_order[$];
   int            wr_fin_cnt, rd_fin_cnt, wr_fin_cyc, rd_fin_cyc;
   int            en_cnt, proto_err, outs_nz;
   int            wr_idx;
   logic [DW-1:0] wbeats[16];
   bit            rand_rdy;

   function automatic logic [DW-1:0] rand512();
      logic [DW-1:0] r;
      for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      cmd_q.delete(); cmd_cyc_q.delete(); wdf_q.delete(); wdf_cyc_q.delete();
      rdq.delete(); rd_cyc_q.delete(); mig_q.delete(); mig_cyc_q.delete();
      due_q.delete(); fin_order.delete();
      wr_fin_cnt = 0; rd_fin_cnt = 0; wr_fin_cyc = -1; rd_fin_cyc = -1;
      en_cnt = 0; proto_err = 0;
   endtask

   // One clock cycle: sample outputs at the falling edge, then update the
   // requester and MIG model just after the rising edge.
   task automatic step();
      logic consumed, wfin, rfin;
      @(negedge ddr_clk);
      outs_nz = (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || wr_burst_data_req !== 1'b0 ||
                 wr_burst_finish !== 1'b0 || rd_burst_finish !== 1'b0 ||
                 rd_burst_data_valid !== 1'b0 || app_addr !== '0 || app_cmd !== 3'b000 ||
                 app_wdf_end !== 1'b0 || app_wdf_data !== '0 || app_wdf_mask !== '0) ? 1 : 0;
      if (app_en === 1'b1) en_cnt++;
      if (app_en === 1'b1 && app_rdy === 1'b1) begin
         cmd_q.push_back({app_cmd, app_addr});
         cmd_cyc_q.push_back(cyc);
         if (app_cmd === 3'b001) due_q.push_back(cyc + RD_LAT);
      end
      if (app_wdf_wren === 1'b1) begin
         wdf_q.push_back(app_wdf_data);
         wdf_cyc_q.push_back(cyc);
         if (app_wdf_rdy !== 1'b1) proto_err++;
      end
      if (app_wdf_end !== app_wdf_wren || wr_burst_data_req !== app_wdf_wren) proto_err++;
      if (app_wdf_mask !== '0) proto_err++;
      if (rd_burst_data_valid === 1'b1) begin
         rdq.push_back(rd_burst_data);
         rd_cyc_q.push_back(cyc);
      end
      consumed = wr_burst_data_req;
      wfin = wr_burst_finish;
      rfin = rd_burst_finish;
      if (wfin === 1'b1) begin wr_fin_cnt++; wr_fin_cyc = cyc; fin_order.push_back(0); end
      if (rfin === 1'b1) begin rd_fin_cnt++; rd_fin_cyc = cyc; fin_order.push_back(1); end
      @(posedge ddr_clk);
      #1;
      cyc++;
      if (consumed === 1'b1) wr_idx++;
      wr_burst_data = wbeats[wr_idx % 16];
      if (wfin === 1'b1) wr_burst_req = 1'b0;
      if (rfin === 1'b1) rd_burst_req = 1'b0;
      if (rand_rdy) begin
         app_rdy     = 1'($urandom_range(0, 1));
         app_wdf_rdy = 1'($urandom_range(0, 1));
      end
      app_rd_data       = rand512();
      app_rd_data_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         void'(due_q.pop_front());
         app_rd_data_valid = 1'b1;
         mig_q.push_back(app_rd_data);
         mig_cyc_q.push_back(cyc);
      end
   endtask

   task automatic start_wr(int len, logic [31:0] addr);
      for (int k = 0; k < 16; k++) wbeats[k] = rand512();
      wr_idx        = 0;
      wr_burst_data = wbeats[0];
      wr_burst_len  = 10'(len);
      wr_burst_addr = addr;
      wr_burst_req  = 1'b1;
   endtask

   task automatic start_rd(int len, logic [31:0] addr);
      rd_burst_len  = 10'(len);
      rd_burst_addr = addr;
      rd_burst_req  = 1'b1;
   endtask

   task automatic run_until(int want_wr, int want_rd, string tag);
      int n = 0;
      while ((wr_fin_cnt < want_wr || rd_fin_cnt < want_rd) && n < 300) begin
         step();
         n++;
      end
      check({tag, "_done"}, (wr_fin_cnt >= want_wr && rd_fin_cnt >= want_rd) ? 1 : 0, 1);
      repeat (6) step();
      check({tag, "_wr_fin_cnt"}, wr_fin_cnt, want_wr);
      check({tag, "_rd_fin_cnt"}, rd_fin_cnt, want_rd);
   endtask

   task automatic check_cmds(string tag, int start, int n, logic [2:0] cmd, logic [31:0] addr);
      logic [30:0]   obs;
      logic [AW-1:0] ea;
      for (int i = 0; i < n; i++) begin
         ea  = AW'(addr) + AW'(i * 8);
         obs = (start + i < cmd_q.size()) ? cmd_q[start+i] : 'x;
         check($sformatf("%s_cmd%0d", tag, i), obs, {cmd, ea});
      end
   endtask

   task automatic check_wdata(string tag, int n);
      logic [DW-1:0] obs;
      check({tag, "_wbeats"}, wdf_q.size(), n);
      check({tag, "_req_cnt"}, wr_idx, n);
      for (int i = 0; i < n; i++) begin
         obs = (i < wdf_q.size()) ? wdf_q[i] : 'x;
         check($sformatf("%s_wdata%0d", tag, i), obs, wbeats[i]);
      end
   endtask

   task automatic check_rdata(string tag, int n);
      logic [DW-1:0] obs;
      int            oc;
      check({tag, "_rbeats"}, rdq.size(), n);
      for (int i = 0; i < n; i++) begin
         obs = (i < rdq.size() && i < mig_q.size()) ? rdq[i] : 'x;
         oc  = (i < rd_cyc_q.size()) ? rd_cyc_q[i] : -1;
         check($sformatf("%s_rdata%0d", tag, i), obs, (i < mig_q.size()) ? mig_q[i] : '1);
         check($sformatf("%s_rcyc%0d", tag, i), oc, (i < mig_cyc_q.size()) ? mig_cyc_q[i] + 1 : -2);
      end
   endtask

   initial begin
      int a, lc, ld;
      logic [31:0] ra;
      ddr_rst = 1'b1; init_calib_complete = 1'b0;
      wr_burst_req = 1'b0; wr_burst_len = '0; wr_burst_addr = '0;
      rd_burst_req = 1'b0; rd_burst_len = '0; rd_burst_addr = '0;
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; rand_rdy = 1'b0;
      app_rd_data = rand512(); app_rd_data_valid = 1'b1;
      wr_burst_data = rand512(); wr_idx = 0;
      for (int k = 0; k < 16; k++) wbeats[k] = '0;
      clear_mon();

      // Reset state, with MIG read-valid asserted to show it is ignored.
      repeat (3) @(posedge ddr_clk);
      @(negedge ddr_clk);
      check("rst_app_en", app_en, 0);
      check("rst_wren", app_wdf_wren, 0);
      check("rst_rd_valid", rd_burst_data_valid, 0);
      check("rst_finish", {wr_burst_finish, rd_burst_finish}, 0);
      check("rst_rd_data", rd_burst_data, 0);
      @(posedge ddr_clk); #1;
      ddr_rst = 1'b0; app_rd_data_valid = 1'b0;
      step(); step();
      check("idle_outs_zero", outs_nz, 0);

      // Tie from reset: write first, then read.
      init_calib_complete = 1'b1;
      clear_mon();
      start_wr(2, 32'h200);
      start_rd(2, 32'h300);
      run_until(1, 1, "tie");
      check("tie_nfin", fin_order.size(), 2);
      check("tie_first_wr", (fin_order.size() > 0) ? fin_order[0] : -1, 0);
      check("tie_second_rd", (fin_order.size() > 1) ? fin_order[1] : -1, 1);
      check("tie_ncmd", cmd_q.size(), 4);
      check_cmds("tie_w", 0, 2, 3'b000, 32'h200);
      check_cmds("tie_r", 2, 2, 3'b001, 32'h300);
      check_wdata("tie", 2);
      check_rdata("tie", 2);

      // Write len=4 at 0x40, always ready.
      clear_mon();
      a = cyc;
      start_wr(4, 32'h40);
      run_until(1, 0, "w4");
      check("w4_ncmd", cmd_q.size(), 4);
      check_cmds("w4", 0, 4, 3'b000, 32'h40);
      check_wdata("w4", 4);
      check("w4_first_cmd_cyc", (cmd_cyc_q.size() > 0) ? cmd_cyc_q[0] : -1, a + 1);
      check("w4_last_cmd_cyc", (cmd_cyc_q.size() > 3) ? cmd_cyc_q[3] : -1, a + 4);
      check("w4_fin_cyc", wr_fin_cyc, a + 5);

      // Write len=8 with independent random ready patterns.
      clear_mon();
      ra = $urandom;
      rand_rdy = 1'b1;
      start_wr(8, ra);
      run_until(1, 0, "w8");
      rand_rdy = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      check("w8_ncmd", cmd_q.size(), 8);
      check_cmds("w8", 0, 8, 3'b000, ra);
      check_wdata("w8", 8);
      check("w8_proto", proto_err, 0);
      lc = (cmd_cyc_q.size() > 0) ? cmd_cyc_q[$] : -100;
      ld = (wdf_cyc_q.size() > 0) ? wdf_cyc_q[$] : -100;
      check("w8_fin_cyc", wr_fin_cyc, ((lc > ld) ? lc : ld) + 1);

      // Read len=4 at 0x100, MIG returns each beat 5 cycles after its command.
      clear_mon();
      a = cyc;
      start_rd(4, 32'h100);
      run_until(0, 1, "r4");
      check("r4_ncmd", cmd_q.size(), 4);
      check_cmds("r4", 0, 4, 3'b001, 32'h100);
      check_rdata("r4", 4);
      check("r4_fin_cyc", rd_fin_cyc, a + 11);

      // Zero-length write held while calibration is low.
      clear_mon();
      init_calib_complete = 1'b0;
      start_wr(0, 32'h80);
      repeat (8) step();
      check("z_no_fin_uncal", wr_fin_cnt, 0);
      init_calib_complete = 1'b1;
      a = cyc;
      step();
      check("z_no_early_fin", wr_fin_cnt, 0);
      step();
      check("z_fin", wr_fin_cnt, 1);
      check("z_fin_cyc", wr_fin_cyc, a + 1);
      repeat (6) step();
      check("z_single_fin", wr_fin_cnt, 1);
      check("z_no_app_en", en_cnt, 0);

      // Reset in the middle of a 6-beat write.
      clear_mon();
      start_wr(6, 32'h1000);
      for (int n = 0; n < 50 && wdf_q.size() < 2; n++) step();
      ddr_rst = 1'b1;
      step();
      ddr_rst = 1'b0;
      wr_burst_req = 1'b0;
      step();
      check("mrst_outs_zero", outs_nz, 0);
      repeat (8) step();
      check("mrst_no_fin", wr_fin_cnt, 0);

      // Fresh burst afterwards, address wrapping at 2^28.
      clear_mon();
      start_wr(2, 32'h1FFF_FFF8);
      run_until(1, 0, "post");
      check("post_ncmd", cmd_q.size(), 2);
      check_cmds("post", 0, 2, 3'b000, 32'h1FFF_FFF8);
      check_wdata("post", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ddr_burst_bridge.md
Name: ddr_burst_bridge

Overview:
- Responder end of the team's DDR burst request interface (wr/rd_burst_req, len, addr, data_req, data_valid, finish).
- Accepts one burst at a time from a requester such as the DDR read/write test generator or the acquisition write path.
- Translates each burst into MIG UltraScale native app commands: one app command and one write-data beat per 512-bit beat, 4:1 mode.
- Returns read data and a finish pulse per burst.

Parameters:
- DDR_ADDR_WD, 32, requester address width
- DDR_DATA_WD, 512, beat data width (= MIG app data width)
- APP_ADDR_WD, 28, MIG app_addr width
- ADDR_STEP, 8, app_addr increment per beat

Ports:
- ddr_clk  in  1  MIG ui_clk; single clock domain
- ddr_rst  in  1  synchronous, active-high reset
- init_calib_complete  in  1  MIG calibration done
- wr_burst_req  in  1  write burst request; held until wr_burst_finish
- wr_burst_len  in  10  beats in write burst
- wr_burst_addr  in  DDR_ADDR_WD  write start address
- wr_burst_data_req  out  1  beat consumed this cycle; requester advances data next cycle
- wr_burst_data  in  DDR_DATA_WD  write beat, valid in the same cycle as wr_burst_data_req
- wr_burst_finish  out  1  one-cycle pulse, write burst complete
- rd_burst_req  in  1  read burst request; held until rd_burst_finish
- rd_burst_len  in  10  beats in read burst
- rd_burst_addr  in  DDR_ADDR_WD  read start address
- rd_burst_data_valid  out  1  read beat valid
- rd_burst_data  out  DDR_DATA_WD  read beat
- rd_burst_finish  out  1  one-cycle pulse, read burst complete
- app_addr  out  APP_ADDR_WD  MIG command address
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_en  out  1  command valid
- app_rdy  in  1  command accepted when app_en && app_rdy
- app_wdf_data  out  DDR_DATA_WD  write data
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  equals app_wdf_wren
- app_wdf_mask  out  DDR_DATA_WD/8  tied 0
- app_wdf_rdy  in  1  write FIFO ready
- app_rd_data  in  DDR_DATA_WD  read data
- app_rd_data_valid  in  1  read data valid

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All counters 0.
  - All outputs 0, including wr_burst_finish, rd_burst_finish, rd_burst_data_valid, app_en and app_wdf_wren.
- FSM states: IDLE, WR, RD.
- IDLE: acts only when init_calib_complete=1.
  - If only one request is high, accept it.
  - If both are high, grant the opposite of the last granted direction; last_grant resets to RD, so write wins the first tie.
  - On accept, latch len into blen, latch addr[APP_ADDR_WD-1:0] into base, clear cmd_cnt, dat_cnt and beat_cnt.
- Zero-length burst (blen==0): pulse the matching finish on the cycle after accept and return to IDLE. No app traffic.
- WR state:
  - app_en = (cmd_cnt<blen), app_cmd=000, app_addr = base + cmd_cnt*ADDR_STEP, truncated to APP_ADDR_WD.
  - cmd_cnt increments on app_en&&app_rdy.
  - wr_burst_data_req = app_wdf_wren = (dat_cnt<blen) && app_wdf_rdy. This is combinational from app_wdf_rdy.
  - app_wdf_data = wr_burst_data, passed through.
  - dat_cnt increments on wr_burst_data_req.
  - Data may lead or lag commands; the two sides are independent.
  - When cmd_cnt==blen && dat_cnt==blen: wr_burst_finish=1 for one cycle (registered), return to IDLE on the same edge.
- RD state:
  - app_en = (cmd_cnt<blen), app_cmd=001, same address rule.
  - rd_burst_data/rd_burst_data_valid are app_rd_data/app_rd_data_valid registered by 1 cycle, gated by state==RD.
  - beat_cnt counts registered valid beats.
  - rd_burst_finish pulses 1 cycle after the last (blen-th) rd_burst_data_valid, then return to IDLE.
  - Excess app_rd_data_valid beyond blen is dropped.
- Finish pulses never coincide with an accept. After a finish the FSM sits in IDLE at least one cycle, so a request still held high during the finish cycle is not re-accepted.
- Counters are 10-bit. Address arithmetic is modulo 2^APP_ADDR_WD and wraps silently.
- Request inputs, len and addr are ignored outside IDLE; changes mid-burst have no effect.
- init_calib_complete falling mid-burst: the current burst completes normally; no new accept until it rises again.
- ddr_rst mid-burst: FSM goes to IDLE next edge and all outputs go 0. The burst is abandoned with no finish pulse. Late app_rd_data_valid after reset is dropped.

Test Plan:
- Write len=4, addr=0x40, app_rdy=app_wdf_rdy=1 -> app_addr 0x40,0x48,0x50,0x58 on 4 consecutive cycles; 4 wr_burst_data_req pulses; app_wdf_data matches wr_burst_data per beat; wr_burst_finish 1 cycle after the 4th beat.
- Write len=8 with app_rdy and app_wdf_rdy toggled by independent random patterns -> exactly 8 commands and 8 data beats, no beat while app_wdf_rdy=0, single finish pulse.
- Read len=4, addr=0x100, MIG returns data 5 cycles after each command -> 4 rd_burst_data_valid beats with data equal to app_rd_data delayed 1 cycle; rd_burst_finish 1 cycle after the 4th beat.
- wr_burst_req and rd_burst_req high together from reset, len=2 -> write served first; then read served; finish pulses in order WR then RD.
- len=0 write, plus init_calib_complete=0 while a request is pending -> no accept until calibration completes; then finish with no app_en.
- ddr_rst asserted after 2 of 6 write beats -> all outputs 0 next cycle, no finish; a fresh len=2 burst afterwards completes correctly from the new address.
